// File: rtl/bow_charge_ctrl.sv
// Bow charge sequencer: turns the fire button into a frame-synchronous charge
// animation and a one-cycle shot pulse carrying the charge power.
module bow_charge_ctrl #(
    parameter int STAGE_FRAMES    = 20,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       fire_btn,
    output logic [1:0] bow_frame,
    output logic       shoot,
    output logic [1:0] shoot_power,
    output logic       busy
);

    localparam int CNT_MAX = (STAGE_FRAMES > COOLDOWN_FRAMES) ? STAGE_FRAMES : COOLDOWN_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       stage;
    logic             btn_meta;
    logic             btn_s;
    logic             btn_prev;
    logic             match_d;
    logic             match;
    logic             tick;

    // Edge-detect the last visible pixel so a stalled pixel still gives one tick per frame.
    assign match = (DrawX == 10'd639) && (DrawY == 10'd479);
    assign tick  = match & ~match_d;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            stage       <= 2'd0;
            btn_meta    <= 1'b0;
            btn_s       <= 1'b0;
            btn_prev    <= 1'b1;
            match_d     <= 1'b0;
            bow_frame   <= 2'd0;
            shoot       <= 1'b0;
            shoot_power <= 2'd0;
            busy        <= 1'b0;
        end else begin
            btn_meta <= fire_btn;
            btn_s    <= btn_meta;
            match_d  <= match;
            shoot    <= 1'b0;

            if (tick) begin
                // btn_prev tracks every tick, including cooldown, so a held button needs a re-press.
                btn_prev <= btn_s;
                case (state)
                    IDLE: begin
                        if (btn_s && !btn_prev) begin
                            state     <= CHARGE;
                            stage     <= 2'd1;
                            cnt       <= '0;
                            bow_frame <= 2'd1;
                            busy      <= 1'b1;
                        end
                    end
                    CHARGE: begin
                        if (!btn_s) begin
                            shoot       <= 1'b1;
                            shoot_power <= stage;
                            stage       <= 2'd0;
                            cnt         <= '0;
                            state       <= COOLDOWN;
                            bow_frame   <= 2'd0;
                        end else if (cnt == STAGE_LAST && stage != 2'd3) begin
                            stage     <= stage + 2'd1;
                            cnt       <= '0;
                            bow_frame <= stage + 2'd1;
                        end else if (stage == 2'd3) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    COOLDOWN: begin
                        if (cnt == COOL_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cnt       <= '0;
                        stage     <= 2'd0;
                        bow_frame <= 2'd0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bow_charge_ctrl.sv
// Directed bench for bow_charge_ctrl using a compressed frame: one tick per
// FRAME_LEN cycles, with the (639,479) pixel optionally held for several cycles.
module tb_bow_charge_ctrl;

    localparam int FRAME_LEN = 300;
    localparam int TICK_POS  = 250;

    logic       vga_clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       fire_btn;
    logic [1:0] bow_frame;
    logic       shoot;
    logic [1:0] shoot_power;
    logic       busy;

    int frame_pos = 0;
    int match_len = 1;
    int checks    = 0;
    int errors    = 0;

    typedef struct {
        logic       btn;
        logic [1:0] frame;
        logic       shoot;
        logic [1:0] power;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    bow_charge_ctrl #(
        .STAGE_FRAMES   (2),
        .COOLDOWN_FRAMES(3)
    ) dut (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .fire_btn   (fire_btn),
        .bow_frame  (bow_frame),
        .shoot      (shoot),
        .shoot_power(shoot_power),
        .busy       (busy)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        frame_pos <= (frame_pos == FRAME_LEN - 1) ? 0 : frame_pos + 1;
    end

    always_comb begin
        DrawX = 10'(frame_pos);
        DrawY = 10'd0;
        if (frame_pos >= TICK_POS && frame_pos < TICK_POS + match_len) begin
            DrawX = 10'd639;
            DrawY = 10'd479;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic wait_pos(input int pos);
        int n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (frame_pos != pos && n < 2 * FRAME_LEN);
        if (frame_pos != pos) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_pos actual=%0d expected=%0d", frame_pos, pos);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        wait_pos(20);
        fire_btn = v.btn;
        wait_pos(TICK_POS);
        @(posedge vga_clk);
        #1;
        checkOutput({tag, " bow_frame"}, bow_frame, v.frame);
        checkOutput({tag, " shoot"}, shoot, v.shoot);
        checkOutput({tag, " shoot_power"}, shoot_power, v.power);
        checkOutput({tag, " busy"}, busy, v.busy);
        @(posedge vga_clk);
        #1;
        checkOutput({tag, " shoot_drop"}, shoot, 0);
        // Sample again after any held-pixel window to catch extra ticks.
        repeat (4) @(posedge vga_clk);
        #1;
        checkOutput({tag, " bow_frame_late"}, bow_frame, v.frame);
        checkOutput({tag, " busy_late"}, busy, v.busy);
    endtask

    function automatic void add_vec(input logic btn, input logic [1:0] frame, input logic shoot_e,
                                    input logic [1:0] power, input logic busy_e);
        vec_t v;
        v.btn   = btn;
        v.frame = frame;
        v.shoot = shoot_e;
        v.power = power;
        v.busy  = busy_e;
        vecs.push_back(v);
    endfunction

    initial begin
        int mid_reset_idx;
        int glitch_idx;
        int hold_idx;

        // Held through reset, then no charge while held; release arms the press detector.
        repeat (3) add_vec(1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0);
        // Short shot at stage 1, then three cooldown ticks.
        add_vec(1, 1, 0, 0, 1);
        add_vec(0, 0, 1, 1, 1);
        add_vec(0, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 1);
        add_vec(0, 0, 0, 1, 0);
        // Full charge up to saturated stage 3.
        add_vec(1, 1, 0, 1, 1);
        add_vec(1, 1, 0, 1, 1);
        add_vec(1, 2, 0, 1, 1);
        add_vec(1, 2, 0, 1, 1);
        repeat (4) add_vec(1, 3, 0, 1, 1);
        add_vec(0, 0, 1, 3, 1);
        // Button held through cooldown and back into idle.
        add_vec(1, 0, 0, 3, 1);
        add_vec(1, 0, 0, 3, 1);
        add_vec(1, 0, 0, 3, 0);
        add_vec(1, 0, 0, 3, 0);
        add_vec(0, 0, 0, 3, 0);
        add_vec(1, 1, 0, 3, 1);
        add_vec(1, 1, 0, 3, 1);
        add_vec(1, 2, 0, 3, 1);
        mid_reset_idx = vecs.size();
        add_vec(1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0);
        glitch_idx = vecs.size();
        add_vec(0, 0, 0, 0, 0);
        hold_idx = vecs.size();
        add_vec(1, 1, 0, 0, 1);
        add_vec(1, 1, 0, 0, 1);
        add_vec(1, 2, 0, 0, 1);
        add_vec(0, 0, 1, 2, 1);
        add_vec(0, 0, 0, 2, 1);
        add_vec(0, 0, 0, 2, 1);
        add_vec(0, 0, 0, 2, 0);

        Reset    = 1'b1;
        fire_btn = 1'b1;
        repeat (5) @(posedge vga_clk);
        #1;
        checkOutput("reset bow_frame", bow_frame, 0);
        checkOutput("reset shoot", shoot, 0);
        checkOutput("reset shoot_power", shoot_power, 0);
        checkOutput("reset busy", busy, 0);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == mid_reset_idx) begin
                Reset = 1'b1;
                @(posedge vga_clk);
                #1;
                checkOutput("midreset bow_frame", bow_frame, 0);
                checkOutput("midreset shoot", shoot, 0);
                checkOutput("midreset shoot_power", shoot_power, 0);
                checkOutput("midreset busy", busy, 0);
                Reset = 1'b0;
            end
            if (i == glitch_idx) begin
                wait_pos(20);
                fire_btn = 1'b1;
                repeat (100) @(negedge vga_clk);
                fire_btn = 1'b0;
                wait_pos(TICK_POS);
                @(posedge vga_clk);
                #1;
                checkOutput("glitch bow_frame", bow_frame, 0);
                checkOutput("glitch busy", busy, 0);
            end
            if (i == hold_idx) begin
                match_len = 4;
            end
            applyStimulus(vecs[i], i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bow_charge_ctrl.md
# bow_charge_ctrl

Frame-synchronous sequencer for the bow sprite. It turns the player's fire button into a charge animation (bow frame 0–3) and a one-cycle shot pulse carrying the charge power. It sits between the input/keycode logic and the bow sprite renderers: `bow_frame` selects which bow ROM/palette instance feeds the compositor, and `shoot`/`shoot_power` go to the arrow spawner. All visible changes are committed once per video frame, at the last visible pixel, so the bow never tears mid-frame.

## Interface
- `STAGE_FRAMES`, 20: video frames spent in each charge stage before advancing.
- `COOLDOWN_FRAMES`, 30: video frames after a shot during which the button is ignored.
- `vga_clk`  in  1  pixel clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `DrawX`  in  10  current pixel column from the VGA controller.
- `DrawY`  in  10  current pixel row from the VGA controller.
- `fire_btn`  in  1  fire button level (1 = held); asynchronous to `vga_clk`.
- `bow_frame`  out  2  bow sprite select: 0 = relaxed, 1–3 = charge stages.
- `shoot`  out  1  one-cycle pulse when an arrow is released.
- `shoot_power`  out  2  charge stage (1–3) of the most recent shot; held until the next shot.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **Button synchronizer:** `fire_btn` passes through two flops to give `btn_s`.
- **Frame tick:**
  - `match` = (`DrawX` == 639 && `DrawY` == 479); `match_d` is `match` registered.
  - `tick` = `match` & ~`match_d`, so there is exactly one pulse per frame even if the pixel is held for several cycles.
- **Button sampling:** `btn_s` is sampled only on `tick`. Its value at the previous tick is kept in `btn_prev`. Button activity between ticks has no effect.
- **State machine:** states are IDLE, CHARGE and COOLDOWN. The state and all counters change only on cycles where `tick` = 1.
  - **IDLE:** `bow_frame` = 0.
    - On `tick` with `btn_s` = 1 and `btn_prev` = 0 (a press edge): go to CHARGE with stage = 1, cnt = 0.
    - A button held continuously does not start a charge.
  - **CHARGE:** `bow_frame` = stage.
    - On `tick` with `btn_s` = 0: set `shoot` = 1 for one cycle, set `shoot_power` = stage, set stage = 0, cnt = 0, and go to COOLDOWN.
    - On `tick` with `btn_s` = 1 and cnt == `STAGE_FRAMES`-1 and stage < 3: stage increments and cnt = 0.
    - On `tick` with `btn_s` = 1 and stage == 3: stage saturates at 3 and cnt stays at 0.
    - On any other `tick` with `btn_s` = 1: cnt increments.
  - **COOLDOWN:** `bow_frame` = 0; the button is ignored.
    - On `tick`: cnt increments; when cnt == `COOLDOWN_FRAMES`-1, go to IDLE with cnt = 0.
    - `btn_prev` keeps updating during COOLDOWN, so a button still held on return to IDLE needs a release and a new press.
- **Widths:** cnt must be at least clog2(max(`STAGE_FRAMES`, `COOLDOWN_FRAMES`)) bits and must never wrap. Stage is 2 bits.

## Timing
- **Reset** (synchronous, takes priority over everything, including mid-charge):
  - state = IDLE; `bow_frame` = 0, `shoot` = 0, `shoot_power` = 0, `busy` = 0; cnt = 0, stage = 0.
  - Both synchronizer flops = 0; `match_d` = 0.
  - `btn_prev` = 1, so a button held through reset does not start a charge.
- **Output registers:** all outputs are registered. They change on the clock edge where `tick` = 1 and are visible from the next cycle, which is in vertical blanking before row 0 of the next frame.
- **`shoot`:** high for exactly one `vga_clk` cycle per shot. It is never asserted in IDLE or COOLDOWN and never while `Reset` is high.
- **Charge stage durations:** stage 1 lasts `STAGE_FRAMES` ticks, then stage 2 lasts `STAGE_FRAMES` ticks, then stage 3 holds indefinitely.
- **Input latency:** a press is seen on the first `tick` at least 2 cycles after `fire_btn` rises (synchronizer latency). A press shorter than one frame that misses every tick is ignored.
- **`busy`:** rises with entry to CHARGE and falls on the cycle after the final COOLDOWN tick.

## Test plan
Run with `STAGE_FRAMES` = 2, `COOLDOWN_FRAMES` = 3, and a pixel counter driving `DrawX`/`DrawY`.
1. **Reset:** assert `Reset` for 5 cycles -> all outputs 0 and state IDLE. Holding `fire_btn` = 1 through reset and for 3 ticks after it -> `bow_frame` stays 0.
2. **Short shot:** press before tick 1, release before tick 2 -> `bow_frame` = 1 after tick 1. After tick 2: `shoot` high for 1 cycle, `shoot_power` = 1, `bow_frame` = 0. `busy` falls after tick 5.
3. **Full charge:** press before tick 1, hold through tick 8, release before tick 9 -> `bow_frame` = 1 after ticks 1–2, 2 after ticks 3–4, 3 after ticks 5–8. After tick 9: `shoot` pulse with `shoot_power` = 3.
4. **Held through cooldown:** keep `fire_btn` = 1 after a shot -> stays IDLE with `bow_frame` = 0. After a release (sampled low on a tick) and a new press -> CHARGE with `bow_frame` = 1.
5. **Reset mid-charge:** at stage 2, pulse `Reset` for 1 cycle -> `bow_frame` = 0 next cycle, no `shoot` pulse, `busy` = 0, `shoot_power` = 0.
6. **Glitches and ticks:**
   - In IDLE, pulse `fire_btn` for 100 cycles between ticks -> no state change.
   - Hold `DrawX`/`DrawY` at (639, 479) for 4 cycles -> exactly one tick (one counter advance).
